// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake between a producer, the TX FIFO and a downstream uart_tx.
// slave is the FIFO side; master is whoever drives writes and the uart_tx busy.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          tx_busy;
  logic          tx_send;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, clr_ovf, tx_busy,
    input  tx_send, tx_data, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_busy,
    output tx_send, tx_data, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a uart_tx: one-cycle send pulse per byte, sticky overflow.
// state     | meaning
// IDLE      | waiting for a queued byte and tx_busy=0
// SEND      | tx_send high for this single cycle
// WAIT_BUSY | waiting for uart_tx to raise busy (2-cycle timeout)
// WAIT_DONE | waiting for busy to fall
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_fifo_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int TMO = 2;

  state_t          state, state_nx;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;
  logic [1:0]      tmr, tmr_nx;
  logic            pop, wr_acc;
  logic            ovf;
  logic            tx_send_q;
  logic [7:0]      tx_data_q;
  logic            full_w, empty_w;

  assign full_w  = (cnt == (AW+1)'(DEPTH));
  assign empty_w = (cnt == '0);
  assign wr_acc  = bus.wr_en && !full_w;

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_w && !bus.tx_busy) begin
          pop      = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        state_nx = WAIT_BUSY;
        tmr_nx   = 2'(TMO - 1);
      end
      WAIT_BUSY: begin
        // a load uart_tx never acknowledged is abandoned, not retried
        if (bus.tx_busy)     state_nx = WAIT_DONE;
        else if (tmr == '0)  state_nx = IDLE;
        else                 tmr_nx   = tmr - 1'b1;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      tx_send_q <= pop;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        tx_data_q <= mem[rd_ptr];
      end
      case ({wr_acc, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // a dropped write wins over a same-cycle clear
      if (bus.wr_en && full_w) ovf <= 1'b1;
      else if (bus.clr_ovf)    ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.tx_send  = tx_send_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences,
// and a randomized stream checked against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int M_IDLE = 0, M_SEND = 1, M_WB = 2, M_WD = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.AW(AW)) bus();
  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [7:0] mq[$];
  int         m_mode;
  int         m_wait;
  bit         m_send;
  logic [7:0] m_data;
  bit         m_ovf;
  int         m_acc_total;
  logic [7:0] got[$];

  // uart_tx responder
  bit resp_on;
  bit miss_en;
  int busy_len;
  int busy_cnt;
  bit load_pend;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       co;
    logic       busy;
    logic       e_send;
    logic [7:0] e_data;
    int         e_count;
    logic       e_empty;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", nm, g, e, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_mode = M_IDLE; m_wait = 0; m_send = 0; m_data = 8'h00; m_ovf = 0;
    busy_cnt = 0; load_pend = 0;
  endtask

  // advance one clock: model predicts the edge, then DUT is compared
  task automatic tick();
    bit full_m, empty_m, pop, acc, b_before;
    full_m   = (mq.size() == DEPTH);
    empty_m  = (mq.size() == 0);
    b_before = bus.tx_busy;
    pop = (m_mode == M_IDLE) && !empty_m && !bus.tx_busy;
    acc = bus.wr_en && !full_m;
    if (bus.wr_en && full_m) m_ovf = 1;
    else if (bus.clr_ovf)    m_ovf = 0;
    m_send = 0;
    if (pop) begin
      m_data = mq.pop_front();
      m_send = 1;
      m_mode = M_SEND;
    end else begin
      case (m_mode)
        M_SEND: begin m_mode = M_WB; m_wait = 0; end
        M_WB: begin
          if (bus.tx_busy) m_mode = M_WD;
          else begin
            m_wait++;
            if (m_wait == 2) m_mode = M_IDLE;
          end
        end
        M_WD: if (!bus.tx_busy) m_mode = M_IDLE;
        default: ;
      endcase
    end
    if (acc) begin
      mq.push_back(bus.wr_data);
      m_acc_total++;
    end
    @(posedge clk); #1;
    chk("count",    bus.count,    mq.size());
    chk("empty",    bus.empty,    mq.size() == 0);
    chk("full",     bus.full,     mq.size() == DEPTH);
    chk("overflow", bus.overflow, m_ovf);
    chk("tx_send",  bus.tx_send,  m_send);
    chk("tx_data",  bus.tx_data,  m_data);
    if (bus.tx_send) begin
      got.push_back(bus.tx_data);
      chk("send_busy_low", b_before, 1'b0);
    end
  endtask

  task automatic step();
    tick();
    if (resp_on) begin
      if (load_pend) begin
        busy_cnt  = (miss_en && $urandom_range(0, 7) == 0) ? 0 : busy_len;
        load_pend = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (m_send) load_pend = 1;
      bus.tx_busy = (busy_cnt > 0);
    end
  endtask

  task automatic drain();
    bus.wr_en = 0; bus.clr_ovf = 0;
    if (!resp_on) bus.tx_busy = 0;
    for (int i = 0; i < 400 && !(mq.size() == 0 && m_mode == M_IDLE && !bus.tx_busy
                                 && busy_cnt == 0 && !load_pend); i++)
      step();
    chk("drain_count", bus.count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1, 8'hA5, 0, 0, 0, 8'h00, 1, 0};
    vt[1]  = '{0, 8'h00, 0, 0, 1, 8'hA5, 0, 1};
    vt[2]  = '{0, 8'h00, 0, 0, 0, 8'hA5, 0, 1};
    vt[3]  = '{1, 8'h77, 0, 0, 0, 8'hA5, 1, 0};
    vt[4]  = '{0, 8'h00, 0, 0, 0, 8'hA5, 1, 0};
    vt[5]  = '{0, 8'h00, 0, 0, 1, 8'h77, 0, 1};
    vt[6]  = '{0, 8'h00, 0, 0, 0, 8'h77, 0, 1};
    vt[7]  = '{0, 8'h00, 0, 0, 0, 8'h77, 0, 1};
    vt[8]  = '{0, 8'h00, 0, 0, 0, 8'h77, 0, 1};
    vt[9]  = '{1, 8'h3C, 0, 1, 0, 8'h77, 1, 0};
    vt[10] = '{0, 8'h00, 0, 1, 0, 8'h77, 1, 0};
    vt[11] = '{0, 8'h00, 0, 0, 1, 8'h3C, 0, 1};
    vt[12] = '{0, 8'h00, 0, 1, 0, 8'h3C, 0, 1};
    vt[13] = '{0, 8'h00, 0, 1, 0, 8'h3C, 0, 1};
    vt[14] = '{0, 8'h00, 0, 1, 0, 8'h3C, 0, 1};
    vt[15] = '{0, 8'h00, 1, 0, 0, 8'h3C, 0, 1};
    vt[16] = '{1, 8'h11, 0, 0, 0, 8'h3C, 1, 0};
    vt[17] = '{0, 8'h00, 0, 0, 1, 8'h11, 0, 1};

    rst_n = 0;
    bus.wr_en = 0; bus.wr_data = 0; bus.clr_ovf = 0; bus.tx_busy = 0;
    resp_on = 0; miss_en = 0; busy_len = 10; m_acc_total = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full",  bus.full, 0);
    chk("rst_send",  bus.tx_send, 0);
    chk("rst_data",  bus.tx_data, 8'h00);
    chk("rst_ovf",   bus.overflow, 0);
    rst_n = 1;

    // single byte, timeout, busy handshake
    for (int i = 0; i < 18; i++) begin
      bus.wr_en = vt[i].we; bus.wr_data = vt[i].wd;
      bus.clr_ovf = vt[i].co; bus.tx_busy = vt[i].busy;
      tick();
      chk($sformatf("vec%0d_send", i),  bus.tx_send, vt[i].e_send);
      chk($sformatf("vec%0d_data", i),  bus.tx_data, vt[i].e_data);
      chk($sformatf("vec%0d_count", i), bus.count,   vt[i].e_count);
      chk($sformatf("vec%0d_empty", i), bus.empty,   vt[i].e_empty);
    end
    drain();

    // ordering through a 10-cycle uart_tx
    resp_on = 1; miss_en = 0; busy_len = 10; got.delete();
    for (int i = 1; i <= 3; i++) begin
      bus.wr_en = 1; bus.wr_data = 8'(i);
      step();
    end
    bus.wr_en = 0;
    for (int i = 0; i < 200 && got.size() < 3; i++) step();
    chk("order_n", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("order_%0d", i), got[i], i + 1);
    drain();

    // full and overflow with busy held high
    resp_on = 0; bus.tx_busy = 1; got.delete();
    for (int i = 0; i <= 16; i++) begin
      bus.wr_en = 1; bus.wr_data = 8'(i);
      step();
    end
    chk("full_flag", bus.full, 1);
    chk("full_count", bus.count, 16);
    chk("ovf_set", bus.overflow, 1);
    bus.wr_data = 8'h99; bus.clr_ovf = 1;
    step();
    chk("ovf_clr_vs_drop", bus.overflow, 1);
    bus.wr_en = 0;
    step();
    chk("ovf_cleared", bus.overflow, 0);
    bus.clr_ovf = 0;
    resp_on = 1; busy_len = 10; busy_cnt = 0; load_pend = 0; bus.tx_busy = 0;
    for (int i = 0; i < 400 && got.size() < 16; i++) step();
    chk("full_out_n", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("full_out_%0d", i), got[i], i);
    drain();

    // randomized stream with concurrent writes and pops
    begin
      int max_cnt = 0;
      int acc0 = m_acc_total;
      miss_en = 1;
      for (int c = 0; c < 700; c++) begin
        bus.wr_en   = (c < 350) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
        bus.wr_data = 8'($urandom);
        bus.clr_ovf = ($urandom_range(0, 15) == 0);
        busy_len    = $urandom_range(2, 8);
        step();
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      end
      chk("rand_max_count_le16", max_cnt <= DEPTH, 1);
      chk("rand_accepted_ge40", (m_acc_total - acc0) >= 40, 1);
      miss_en = 0;
      drain();
    end

    // reset while bytes are queued and the FSM waits for busy to fall
    resp_on = 0; bus.tx_busy = 0;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1; bus.wr_data = 8'hA0 + 8'(i); bus.tx_busy = (i >= 3);
      step();
    end
    bus.wr_en = 0;
    chk("pre_rst_count", bus.count, 5);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_send",  bus.tx_send, 0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_ovf",   bus.overflow, 0);
    m_reset();
    bus.tx_busy = 0;
    @(posedge clk);
    #3 rst_n = 1;
    got.delete();
    for (int i = 0; i < 20; i++) step();
    chk("no_send_after_rst", got.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in bytes; SHALL be a power of two, minimum 2.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe; one byte offered per cycle while high.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 tx_busy  input  1  busy from the downstream uart_tx.
REQ-009 tx_send  output  1  registered one-cycle send pulse to uart_tx.
REQ-010 tx_data  output  8  registered byte to uart_tx; held stable while tx_send is high.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 count  output  AW+1  number of bytes stored.
REQ-014 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-015 Storage SHALL be a circular buffer with AW-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-016 When wr_en=1 and full=0, the block SHALL store wr_data at wr_ptr, increment wr_ptr, and make the byte visible in count after the same edge.
REQ-017 When wr_en=1 and full=1, the block SHALL drop the byte and set overflow. This applies even if a pop occurs on the same edge.
REQ-018 overflow SHALL stay set until clr_ovf=1. If clr_ovf and a dropped write occur on the same edge, overflow SHALL be 1 after that edge.
REQ-019 On an edge with an accepted write and a pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 The pop FSM SHALL have four states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: if empty=0 and tx_busy=0, the FSM SHALL pop the head byte into tx_data, set tx_send to 1, increment rd_ptr, decrement count, and go to SEND; otherwise it SHALL stay in IDLE.
REQ-022 SEND: the FSM SHALL clear tx_send and go to WAIT_BUSY, so tx_send is high for exactly one cycle.
REQ-023 WAIT_BUSY: if tx_busy=1, the FSM SHALL go to WAIT_DONE.
REQ-024 WAIT_BUSY timeout: if tx_busy stays 0 for 2 consecutive cycles, the FSM SHALL return to IDLE. This covers a missed load; the byte is not retried.
REQ-025 WAIT_DONE: if tx_busy=0, the FSM SHALL go to IDLE.
REQ-026 Latency: write accepted at edge N into an empty FIFO with tx_busy=0 and FSM in IDLE gives tx_send=1 during the cycle after edge N+1.
REQ-027 Back-to-back bytes: the next tx_send SHALL occur no earlier than one cycle after tx_busy falls.
REQ-028 tx_data SHALL hold its last value outside send pulses.
REQ-029 empty, full and count SHALL be derived from registered state only, with no combinational path from wr_en.

Reset
REQ-030 While rst_n=0, the block SHALL force the following, regardless of clk: pointers=0, count=0, FSM=IDLE, tx_send=0, tx_data=8'h00, overflow=0, empty=1, full=0.
REQ-031 Storage array contents SHALL NOT require reset.
REQ-032 Reset asserted mid-transfer SHALL discard all queued bytes and any pending send. After release, the FSM SHALL wait in IDLE for tx_busy=0 before the next send.

Verification
REQ-033 Single byte: after reset, tx_busy=0, write 8'hA5 at edge N -> tx_send=1 and tx_data=8'hA5 for exactly one cycle after edge N+1; then count=0, empty=1.
REQ-034 Ordering with a uart_tx model (busy 10 cycles after each send): write 8'h01, 8'h02, 8'h03 on consecutive cycles -> three send pulses carrying 01, 02, 03 in order, each after busy falls.
REQ-035 Full/overflow: tx_busy held 1; write 17 bytes 8'h00..8'h10 -> full=1, count=16, overflow=1, byte 8'h10 dropped; pulse clr_ovf -> overflow=0; release busy -> bytes 00..0F emitted in order.
REQ-036 Wrap and simultaneous access: stream 40 bytes with wr_en coinciding with pops -> count never exceeds 16, pointers wrap, output order matches input.
REQ-037 Timeout: tx_busy tied 0, write 8'h5A -> one send pulse; FSM returns to IDLE after 2 cycles in WAIT_BUSY; no second pulse.
REQ-038 Mid-transfer reset: with 5 bytes queued and FSM in WAIT_DONE, assert rst_n=0 for 1 cycle -> immediately count=0, tx_send=0, empty=1; no further sends occur.
